axis_conv_arb: RTL and testbench

- Packet-level round-robin arbiter that shares one 32-bit AXI-Stream datapath (the input of the conv32_16 width converter) between N_PORTS upstream AXI-Stream sources.
- Holds a grant for a whole packet, through the beat carrying tlast.
- Registers the selected beat into a single output stage.
- Tags each output beat with the source index.

---
 rtl/axis_arb_pkg.sv | 12 +
 rtl/rr_pick.sv | 28 ++
 rtl/axis_conv_arb.sv | 127 ++++++++++++
 tb/tb_axis_conv_arb.sv | 356 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axis_arb_pkg.sv
// Shared types and defaults for the packet-level AXI-Stream arbiter.
package axis_arb_pkg;

    localparam int unsigned N_PORTS_DEF = 4;
    localparam int unsigned DATA_W_DEF  = 32;

    typedef enum logic [0:0] {
        StIdle,
        StPass
    } arb_state_e;

endpackage

// File: rtl/rr_pick.sv
// Rotating priority encoder: returns the first set bit of req when searching
// ptr+1, ptr+2, ... modulo N_PORTS.
module rr_pick #(
    parameter int unsigned N_PORTS = 4,
    parameter int unsigned IDX_W   = 2
) (
    input  logic [N_PORTS-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic               any,
    output logic [IDX_W-1:0]   idx
);

    logic [IDX_W-1:0] cand;

    always_comb begin
        any  = 1'b0;
        idx  = '0;
        cand = '0;
        for (int unsigned i = 1; i <= N_PORTS; i++) begin
            cand = IDX_W'((32'(ptr) + i) % N_PORTS);
            if (!any && req[cand]) begin
                any = 1'b1;
                idx = cand;
            end
        end
    end

endmodule

// File: rtl/axis_conv_arb.sv
// Packet-level round-robin arbiter sharing one AXI-Stream datapath between
// N_PORTS sources, with a single registered output stage tagged by source index.
module axis_conv_arb
    import axis_arb_pkg::*;
#(
    parameter int unsigned N_PORTS = N_PORTS_DEF,
    parameter int unsigned DATA_W  = DATA_W_DEF,
    localparam int unsigned IDX_W  = $clog2(N_PORTS)
) (
    input  logic                      axis_clk,
    input  logic                      axis_rst,
    input  logic [N_PORTS-1:0]        s_tvalid,
    input  logic [N_PORTS-1:0]        s_tlast,
    output logic [N_PORTS-1:0]        s_tready,
    input  logic [N_PORTS*DATA_W-1:0] s_tdata,
    input  logic [N_PORTS-1:0]        port_en,
    output logic                      m_tvalid,
    output logic                      m_tlast,
    input  logic                      m_tready,
    output logic [DATA_W-1:0]         m_tdata,
    output logic [IDX_W-1:0]          m_tid,
    output logic                      grant_valid,
    output logic [IDX_W-1:0]          grant_idx
);

    arb_state_e        state_q, state_d;
    logic [IDX_W-1:0]  grant_idx_q, grant_idx_d;
    logic [IDX_W-1:0]  ptr_q, ptr_d;
    logic              m_tvalid_q, m_tvalid_d;
    logic              m_tlast_q, m_tlast_d;
    logic [DATA_W-1:0] m_tdata_q, m_tdata_d;
    logic [IDX_W-1:0]  m_tid_q, m_tid_d;

    logic [DATA_W-1:0] src_data [N_PORTS];
    logic              slot_free;
    logic              g_valid;
    logic              g_last;
    logic [DATA_W-1:0] g_data;
    logic              pick_any;
    logic [IDX_W-1:0]  pick_idx;

    for (genvar i = 0; i < N_PORTS; i++) begin : g_src
        assign src_data[i] = s_tdata[i*DATA_W +: DATA_W];
    end

    rr_pick #(
        .N_PORTS (N_PORTS),
        .IDX_W   (IDX_W)
    ) u_rr_pick (
        .req (s_tvalid & port_en),
        .ptr (ptr_q),
        .any (pick_any),
        .idx (pick_idx)
    );

    assign slot_free = !m_tvalid_q || m_tready;
    assign g_valid   = s_tvalid[grant_idx_q];
    assign g_last    = s_tlast[grant_idx_q];
    assign g_data    = src_data[grant_idx_q];

    always_comb begin
        state_d     = state_q;
        grant_idx_d = grant_idx_q;
        ptr_d       = ptr_q;
        m_tvalid_d  = m_tvalid_q;
        m_tlast_d   = m_tlast_q;
        m_tdata_d   = m_tdata_q;
        m_tid_d     = m_tid_q;
        s_tready    = '0;

        // Drain first; a load below overrides it.
        if (m_tvalid_q && m_tready) begin
            m_tvalid_d = 1'b0;
        end

        unique case (state_q)
            StIdle: begin
                if (pick_any) begin
                    grant_idx_d = pick_idx;
                    state_d     = StPass;
                end
            end
            StPass: begin
                s_tready[grant_idx_q] = slot_free;
                if (g_valid && slot_free) begin
                    m_tvalid_d = 1'b1;
                    m_tdata_d  = g_data;
                    m_tlast_d  = g_last;
                    m_tid_d    = grant_idx_q;
                    if (g_last) begin
                        ptr_d   = grant_idx_q;
                        state_d = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge axis_clk or negedge axis_rst) begin
        if (!axis_rst) begin
            state_q     <= StIdle;
            grant_idx_q <= '0;
            ptr_q       <= IDX_W'(N_PORTS - 1);
            m_tvalid_q  <= 1'b0;
            m_tlast_q   <= 1'b0;
            m_tdata_q   <= '0;
            m_tid_q     <= '0;
        end else begin
            state_q     <= state_d;
            grant_idx_q <= grant_idx_d;
            ptr_q       <= ptr_d;
            m_tvalid_q  <= m_tvalid_d;
            m_tlast_q   <= m_tlast_d;
            m_tdata_q   <= m_tdata_d;
            m_tid_q     <= m_tid_d;
        end
    end

    assign m_tvalid    = m_tvalid_q;
    assign m_tlast     = m_tlast_q;
    assign m_tdata     = m_tdata_q;
    assign m_tid       = m_tid_q;
    assign grant_valid = (state_q == StPass);
    assign grant_idx   = grant_idx_q;

endmodule

// File: tb/tb_axis_conv_arb.sv
// Scoreboard bench for axis_conv_arb: per-source packet queues feed a
// packet-level round-robin model; a monitor pops expected beats on each output handshake.
module tb_axis_conv_arb;

    localparam int NP = 4;
    localparam int DW = 32;
    localparam int IW = 2;

    typedef struct packed {
        logic [DW-1:0] data;
        logic          last;
    } sbeat_t;

    typedef struct packed {
        logic [DW-1:0] data;
        logic          last;
        logic [IW-1:0] id;
    } obeat_t;

    logic             axis_clk = 1'b0;
    logic             axis_rst;
    logic [NP-1:0]    s_tvalid;
    logic [NP-1:0]    s_tlast;
    logic [NP-1:0]    s_tready;
    logic [NP*DW-1:0] s_tdata;
    logic [NP-1:0]    port_en;
    logic             m_tvalid;
    logic             m_tlast;
    logic             m_tready;
    logic [DW-1:0]    m_tdata;
    logic [IW-1:0]    m_tid;
    logic             grant_valid;
    logic [IW-1:0]    grant_idx;

    axis_conv_arb #(
        .N_PORTS (NP),
        .DATA_W  (DW)
    ) dut (
        .axis_clk    (axis_clk),
        .axis_rst    (axis_rst),
        .s_tvalid    (s_tvalid),
        .s_tlast     (s_tlast),
        .s_tready    (s_tready),
        .s_tdata     (s_tdata),
        .port_en     (port_en),
        .m_tvalid    (m_tvalid),
        .m_tlast     (m_tlast),
        .m_tready    (m_tready),
        .m_tdata     (m_tdata),
        .m_tid       (m_tid),
        .grant_valid (grant_valid),
        .grant_idx   (grant_idx)
    );

    always #5 axis_clk = ~axis_clk;

    int     n_checks = 0;
    int     n_fail   = 0;
    sbeat_t sq [NP][$];   // what each source driver still has to send
    sbeat_t mq [NP][$];   // model's copy of the same backlog
    obeat_t exp_q [$];
    int     gap_cnt [NP];
    int     gap_after [NP];
    int     bip [NP];
    int     pops [NP];
    bit     rand_gaps = 1'b0;
    bit     rand_ready = 1'b0;
    bit     check_en = 1'b1;
    int     model_ptr = NP - 1;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, want);
        end
    endtask

    task automatic load_pkt(input int src, input int nb, input logic [DW-1:0] base, input bit rnd);
        sbeat_t x;
        for (int b = 0; b < nb; b++) begin
            x.data = rnd ? DW'($urandom()) : base + DW'(b);
            x.last = (b == nb - 1);
            sq[src].push_back(x);
            mq[src].push_back(x);
        end
    endtask

    // Whole packets, round robin over sources that still have backlog and are enabled.
    task automatic model_run(input logic [NP-1:0] mask);
        int     win;
        sbeat_t x;
        forever begin
            win = -1;
            for (int s = 1; s <= NP; s++) begin
                if (win < 0 && mask[(model_ptr + s) % NP] && mq[(model_ptr + s) % NP].size() != 0)
                    win = (model_ptr + s) % NP;
            end
            if (win < 0) break;
            do begin
                x = mq[win].pop_front();
                exp_q.push_back('{data: x.data, last: x.last, id: IW'(win)});
            end while (!x.last);
            model_ptr = win;
        end
    endtask

    task automatic wait_exp(input string name, input int limit);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < limit) begin
            @(negedge axis_clk);
            n++;
        end
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL %s: %0d beats still expected after %0d cycles", name, exp_q.size(), n);
            exp_q.delete();
        end
    endtask

    initial begin : driver
        bit     hs [NP];
        sbeat_t b;
        s_tvalid = '0;
        s_tlast  = '0;
        s_tdata  = '0;
        m_tready = 1'b1;
        forever begin
            @(negedge axis_clk);
            for (int i = 0; i < NP; i++) hs[i] = s_tvalid[i] && s_tready[i];
            @(posedge axis_clk);
            #1;
            for (int i = 0; i < NP; i++) begin
                if (hs[i] && sq[i].size() != 0) begin
                    b = sq[i].pop_front();
                    pops[i]++;
                    if (b.last) begin
                        bip[i] = 0;
                    end else begin
                        bip[i]++;
                        if (gap_after[i] != 0 && bip[i] == gap_after[i]) begin
                            gap_cnt[i]   = 5;
                            gap_after[i] = 0;
                        end else if (rand_gaps && $urandom_range(0, 3) == 0) begin
                            gap_cnt[i] = $urandom_range(1, 3);
                        end
                    end
                end
                if (gap_cnt[i] > 0) begin
                    s_tvalid[i] = 1'b0;
                    gap_cnt[i]--;
                end else if (sq[i].size() != 0) begin
                    s_tvalid[i]          = 1'b1;
                    s_tlast[i]           = sq[i][0].last;
                    s_tdata[i*DW +: DW]  = sq[i][0].data;
                end else begin
                    s_tvalid[i] = 1'b0;
                    s_tlast[i]  = 1'b0;
                end
            end
            m_tready = rand_ready ? ($urandom_range(0, 2) != 0) : 1'b1;
        end
    end

    initial begin : monitor
        obeat_t held, want, got;
        bit     stall;
        stall = 1'b0;
        held  = '0;
        forever begin
            @(negedge axis_clk);
            if (!axis_rst) begin
                stall = 1'b0;
                continue;
            end
            got = '{data: m_tdata, last: m_tlast, id: m_tid};
            if (stall) check("hold_stable", 64'(got), 64'(held));
            check("one_ready", 64'($countones(s_tready) <= 1), 64'd1);
            if (m_tvalid && !m_tready) check("full_no_accept", 64'(s_tready), 64'd0);
            if (m_tvalid && m_tready && check_en) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_beat: got 0x%0h, expected no beat", got);
                end else begin
                    want = exp_q.pop_front();
                    check("out_beat", 64'(got), 64'(want));
                end
            end
            stall = m_tvalid && !m_tready;
            held  = got;
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int n, streak, gaps, beats, p0;
        port_en  = '1;
        axis_rst = 1'b0;
        repeat (3) @(negedge axis_clk);
        check("rst_m_tvalid", 64'(m_tvalid), 64'd0);
        check("rst_m_tlast", 64'(m_tlast), 64'd0);
        check("rst_m_tdata", 64'(m_tdata), 64'd0);
        check("rst_m_tid", 64'(m_tid), 64'd0);
        check("rst_s_tready", 64'(s_tready), 64'd0);
        check("rst_grant_valid", 64'(grant_valid), 64'd0);
        check("rst_grant_idx", 64'(grant_idx), 64'd0);
        axis_rst = 1'b1;
        repeat (2) @(negedge axis_clk);

        // Single source, 3-beat packet: latency and back-to-back output.
        load_pkt(0, 3, 32'hA000_0001, 1'b0);
        model_run('1);
        n = 0;
        while (!m_tvalid && n < 20) begin
            @(negedge axis_clk);
            n++;
        end
        check("first_latency", 64'(n), 64'd3);
        streak = 0;
        while (m_tvalid && streak < 10) begin
            streak++;
            @(negedge axis_clk);
        end
        check("burst_len", 64'(streak), 64'd3);
        wait_exp("single", 50);

        // All four sources, 2-beat packets, source 0 twice: one bubble per boundary.
        load_pkt(0, 2, 32'h1000_0000, 1'b0);
        load_pkt(0, 2, 32'h1000_0010, 1'b0);
        load_pkt(1, 2, 32'h1100_0000, 1'b0);
        load_pkt(2, 2, 32'h1200_0000, 1'b0);
        load_pkt(3, 2, 32'h1300_0000, 1'b0);
        model_run('1);
        n = 0;
        while (!m_tvalid && n < 20) begin
            @(negedge axis_clk);
            n++;
        end
        gaps  = 0;
        beats = 0;
        n     = 0;
        while (beats < 10 && n < 40) begin
            if (m_tvalid) beats++;
            else gaps++;
            @(negedge axis_clk);
            n++;
        end
        check("bubbles", 64'(gaps), 64'd4);
        wait_exp("all_four", 50);

        // Randomized traffic with source gaps and output backpressure.
        rand_gaps  = 1'b1;
        rand_ready = 1'b1;
        for (int r = 0; r < 4; r++) begin
            for (int s = 0; s < NP; s++) begin
                repeat ($urandom_range(1, 3)) load_pkt(s, $urandom_range(1, 5), '0, 1'b1);
            end
            model_run('1);
            wait_exp("random", 3000);
            repeat (3) @(negedge axis_clk);
        end
        rand_gaps  = 1'b0;
        rand_ready = 1'b0;
        repeat (2) @(negedge axis_clk);

        // Mask: source 2 waits until its enable comes back.
        port_en = 4'b1011;
        load_pkt(0, 2, 32'h2000_0000, 1'b0);
        load_pkt(0, 1, 32'h2000_0010, 1'b0);
        load_pkt(1, 3, 32'h2100_0000, 1'b0);
        load_pkt(2, 2, 32'h2200_0000, 1'b0);
        load_pkt(3, 2, 32'h2300_0000, 1'b0);
        model_run(4'b1011);
        wait_exp("masked", 300);
        repeat (4) @(negedge axis_clk);
        check("masked_idle", 64'(grant_valid), 64'd0);
        check("masked_pending", 64'(s_tvalid[2]), 64'd1);
        port_en = '1;
        model_run('1);
        wait_exp("unmasked", 100);

        // Granted source 1 stalls mid-packet while source 0 waits.
        p0 = pops[1];
        gap_after[1] = 2;
        load_pkt(1, 4, 32'hB000_0000, 1'b0);
        model_run('1);
        n = 0;
        while (!(grant_valid && grant_idx == 2'd1) && n < 20) begin
            @(negedge axis_clk);
            n++;
        end
        check("stall_granted", 64'(grant_valid && grant_idx == 2'd1), 64'd1);
        load_pkt(0, 2, 32'hC000_0000, 1'b0);
        model_run('1);
        n = 0;
        while (pops[1] < p0 + 2 && n < 30) begin
            @(negedge axis_clk);
            n++;
        end
        repeat (5) begin
            @(negedge axis_clk);
            check("stall_grant_idx", 64'(grant_idx), 64'd1);
            check("stall_grant_valid", 64'(grant_valid), 64'd1);
            check("stall_ready0", 64'(s_tready[0]), 64'd0);
        end
        wait_exp("stall", 100);

        // Reset in the middle of a 4-beat packet.
        check_en = 1'b0;
        p0 = pops[1];
        load_pkt(1, 4, 32'hD000_0000, 1'b0);
        n = 0;
        while (pops[1] < p0 + 2 && n < 30) begin
            @(negedge axis_clk);
            n++;
        end
        @(negedge axis_clk);
        axis_rst = 1'b0;
        #1;
        check("midrst_m_tvalid", 64'(m_tvalid), 64'd0);
        check("midrst_s_tready", 64'(s_tready), 64'd0);
        check("midrst_grant_valid", 64'(grant_valid), 64'd0);
        check("midrst_grant_idx", 64'(grant_idx), 64'd0);
        @(posedge axis_clk);
        #2;
        for (int s = 0; s < NP; s++) begin
            sq[s].delete();
            mq[s].delete();
            gap_cnt[s]   = 0;
            gap_after[s] = 0;
            bip[s]       = 0;
        end
        exp_q.delete();
        load_pkt(2, 2, 32'hE200_0000, 1'b0);
        load_pkt(0, 2, 32'hE000_0000, 1'b0);
        model_ptr = NP - 1;
        model_run('1);
        check_en = 1'b1;
        repeat (3) @(negedge axis_clk);
        axis_rst = 1'b1;
        wait_exp("post_reset", 100);
        repeat (3) @(negedge axis_clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
